// File: rtl/video_line_fetch.sv
// Line prefetcher: fills one half of a ping-pong line buffer from video RAM while
// the other half is streamed out as 8-bit pixel codes, high byte of each word first.
module video_line_fetch #(
  parameter int DEPTH = 512,  // words per buffer half; must be a power of two
  parameter int AW    = 22
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          new_line,
  input  logic          new_pixel,
  input  logic          frame_start,
  input  logic          fetch_en,
  input  logic [AW-1:0] base_addr,
  input  logic [9:0]    words_per_line,
  output logic          mem_req,
  output logic [AW-1:0] mem_addr,
  input  logic          mem_ack,
  input  logic [15:0]   mem_rdata,
  output logic [7:0]    pix_data,
  output logic          pix_valid,
  output logic          underrun
);

  localparam int IW = $clog2(DEPTH);  // word index within one half
  localparam int CW = IW + 1;         // word count, 0..DEPTH
  localparam int BW = IW + 2;         // byte index, 0..2*DEPTH
  localparam logic [BW-1:0] BYTE_MAX = BW'(2 * DEPTH);

  typedef enum logic [1:0] {IDLE, START, REQ} state_t;

  state_t          state, state_next;
  logic            wr_sel, rd_sel;
  logic [CW-1:0]   wr_idx, rd_count;
  logic [AW-1:0]   line_addr;
  logic [BW-1:0]   byte_idx;

  logic [15:0]     buf_mem [0:2*DEPTH-1];
  logic [15:0]     rd_word;
  logic            hit_q, lo_q, byp_q;
  logic [15:0]     byp_data;

  logic [CW-1:0]   wpl;
  logic            ack_ok;
  logic [CW-1:0]   wr_idx_inc;
  logic [CW-1:0]   fill_count;
  logic            last_word;
  logic [AW-1:0]   start_addr;
  logic [IW:0]     wr_addr, rd_addr;
  logic            rd_sel_eff;
  logic [CW-1:0]   rd_count_eff;
  logic [BW-1:0]   byte_eff;
  logic            hit, in_line, bypass;
  logic [15:0]     word_sel;

  assign wpl        = CW'(words_per_line);
  assign mem_req    = (state == REQ);
  // An ack only counts while a request is outstanding.
  assign ack_ok     = mem_ack && (state == REQ);
  assign wr_idx_inc = wr_idx + CW'(1);
  assign fill_count = ack_ok ? wr_idx_inc : wr_idx;
  assign last_word  = ack_ok && (wr_idx_inc == wpl);
  assign start_addr = frame_start ? base_addr : line_addr;
  assign wr_addr    = {wr_sel, wr_idx[IW-1:0]};

  // ---------------------------------------------------------------- fetch FSM
  always_ff @(posedge clk) begin
    // NOTE: state is updated with <= so every process sees the pre-edge value.
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    // NOTE: default assigned first so no path leaves state_next unassigned (no latch).
    state_next = state;
    if (new_line) begin
      state_next = fetch_en ? START : IDLE;
    end else begin
      case (state)
        IDLE:    state_next = IDLE;
        START:   state_next = REQ;
        REQ:     if (last_word) state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // ------------------------------------------------------- fetch datapath
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_sel    <= 1'b0;
      rd_sel    <= 1'b1;
      wr_idx    <= '0;
      rd_count  <= '0;
      line_addr <= '0;
      mem_addr  <= '0;
    end else begin
      if (new_line) begin
        rd_sel   <= wr_sel;
        wr_sel   <= ~wr_sel;
        rd_count <= fill_count;
        wr_idx   <= '0;
      end else if (ack_ok) begin
        wr_idx <= wr_idx_inc;
      end

      if (ack_ok) begin
        mem_addr <= mem_addr + AW'(1);
      end else if (state == START && !new_line) begin
        mem_addr <= start_addr;
      end

      // A START cut short by new_line does not consume a line address.
      if (state == START && !new_line) begin
        line_addr <= start_addr + AW'(words_per_line);
      end else if (frame_start) begin
        line_addr <= base_addr;
      end
    end
  end

  // ------------------------------------------------------------- line buffer
  // NOTE: the buffer RAM has no reset so it maps onto block RAM; fill counts guard stale data.
  always_ff @(posedge clk) begin
    if (ack_ok && !reset) buf_mem[wr_addr] <= mem_rdata;
  end

  // new_line swaps halves in the same cycle, so a pixel strobe there sees the new view.
  assign rd_sel_eff   = new_line ? wr_sel : rd_sel;
  assign rd_count_eff = new_line ? fill_count : rd_count;
  assign byte_eff     = new_line ? '0 : byte_idx;
  assign rd_addr      = {rd_sel_eff, byte_eff[IW:1]};
  assign hit          = byte_eff < {rd_count_eff, 1'b0};
  assign in_line      = byte_eff < {wpl, 1'b0};
  // Only possible when new_line hands over the half that is taking its last write.
  assign bypass       = ack_ok && (wr_addr == rd_addr);

  always_ff @(posedge clk) begin
    if (new_pixel) rd_word <= buf_mem[rd_addr];
  end

  // ------------------------------------------------------------ pixel output
  always_ff @(posedge clk) begin
    if (reset) begin
      pix_valid <= 1'b0;
      hit_q     <= 1'b0;
      lo_q      <= 1'b0;
      byp_q     <= 1'b0;
      byp_data  <= '0;
      byte_idx  <= '0;
      underrun  <= 1'b0;
    end else begin
      pix_valid <= new_pixel;
      if (new_pixel) begin
        hit_q    <= hit;
        lo_q     <= byte_eff[0];
        byp_q    <= bypass;
        byp_data <= mem_rdata;
        byte_idx <= (byte_eff == BYTE_MAX) ? byte_eff : byte_eff + BW'(1);
      end else if (new_line) begin
        byte_idx <= '0;
      end

      if (frame_start) begin
        underrun <= 1'b0;
      end else if (new_pixel && !hit && in_line) begin
        underrun <= 1'b1;
      end
    end
  end

  assign word_sel = byp_q ? byp_data : rd_word;
  assign pix_data = (pix_valid && hit_q) ? (lo_q ? word_sel[7:0] : word_sel[15:8]) : 8'h00;

endmodule

// File: doc/video_line_fetch.md
Name: video_line_fetch

Overview:
- Downstream consumer of the video timing generator.
- Prefetches the next display line from video RAM into a ping-pong line buffer over a 16-bit word request/acknowledge interface.
- Outputs one 8-bit pixel code per new_pixel strobe, high byte of each word first.
- Feeds the pixel decoder / CLUT stage, and flags underruns when a fetch does not finish within one line period.

Parameters:
- DEPTH, 512: words per line buffer half; also the maximum words_per_line.
- AW, 22: word address width of the memory interface.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- new_line  in  1  one-cycle strobe at each line start, from timing
- new_pixel  in  1  one-cycle pixel strobe from timing, only inside the active area
- frame_start  in  1  one-cycle strobe; reloads the line address from base_addr
- fetch_en  in  1  sampled at new_line; 1 = the line after the one now starting is active and must be fetched
- base_addr  in  AW  word address of the first line of the frame
- words_per_line  in  10  words per line, 1..DEPTH
- mem_req  out  1  word read request
- mem_addr  out  AW  word address; stable while mem_req=1
- mem_ack  in  1  one-cycle acknowledge; mem_rdata valid in the same cycle
- mem_rdata  in  16  read data
- pix_data  out  8  pixel code
- pix_valid  out  1  one-cycle strobe; pix_data valid
- underrun  out  1  sticky flag; cleared by frame_start or reset

Behaviour:
- Reset values:
  - mem_req=0, mem_addr=0, pix_data=0, pix_valid=0, underrun=0.
  - FSM=IDLE; wr_sel=0, rd_sel=1; both fill counts 0; line address register=0.
  - Reset mid-fetch aborts immediately; mem_req=0 in the next cycle.
- Line address register:
  - frame_start loads it with base_addr.
  - It advances by words_per_line at each fetch start, so every fetched line begins at the previous start + words_per_line. Wraps modulo 2^AW.
  - frame_start and new_line in the same cycle: the fetch starting there uses base_addr.
- FSM states: IDLE, START, REQ.
  - Any state, on new_line:
    - swap buffers: rd_sel<=wr_sel, wr_sel<=!wr_sel;
    - latch the completed fill count as rd_count;
    - reset the write word index to 0;
    - go to START if fetch_en=1, else IDLE.
  - START: mem_req=0 for exactly one cycle. mem_addr<=line address; the line address register advances. Go to REQ.
  - REQ: mem_req=1.
    - On mem_ack: write mem_rdata to buffer[wr_sel][index]; index+1; mem_addr+1.
    - When index reaches words_per_line: go to IDLE with mem_req=0 in the next cycle.
  - new_line while in REQ without ack: the fetch is aborted. The partial count becomes rd_count, and mem_req drops for the START cycle.
  - mem_ack in the same cycle as new_line: the word is written into the completing buffer and counted before the swap.
  - mem_ack while mem_req=0 is ignored.
- Pixel output:
  - The byte index is reset to 0 by new_line.
  - new_pixel reads byte index b from buffer[rd_sel], word b>>1: even b gives bits 15:8, odd b gives bits 7:0.
  - Latency: pix_valid and pix_data appear 1 cycle after new_pixel (registered RAM read).
  - b >= 2*rd_count (unfetched or past end): pix_data=0x00, pix_valid=1, underrun<=1 for b < 2*words_per_line.
  - Bytes beyond 2*words_per_line output 0x00 without setting underrun.
  - The byte index saturates at 2*DEPTH.
  - new_pixel in the same cycle as new_line reads the new rd_sel at index 0.
- Buffer RAM: 2*DEPTH x 16, one write port (fetch) and one read port (pixel), inferable as block RAM.

Test Plan:
- Basic line: base_addr=0x100, words_per_line=4, fetch_en=1 at new_line, single-cycle acks with data 0xA1B2,0xC3D4,0xE5F6,0x0718. Required:
  - mem_addr 0x100..0x103, then mem_req=0;
  - after the next new_line, 8 new_pixel strobes give A1,B2,C3,D4,E5,F6,07,18;
  - underrun=0.
- Address progression: words_per_line=4 over three fetched lines after frame_start → line start addresses 0x100, 0x104, 0x108. A frame_start then gives 0x100 again.
- Abort and underrun: words_per_line=4, only 2 acks before the next new_line. Required:
  - mem_req low for one cycle, then restarts at the new line address;
  - pixels 5..8 of the aborted line are 0x00;
  - underrun=1 until frame_start.
- Simultaneous events: ack of the last word in the same cycle as new_line → the word is counted; line displays fully; no underrun.
- fetch_en=0 at new_line → mem_req stays 0 for the whole line; the line address does not advance.
- Reset asserted while mem_req=1 → next cycle mem_req=0, pix_valid=0, underrun=0. Fetching resumes correctly after reset is released.
